// File: rtl/mem_port_sequencer.sv
// Shares one byte-wide single-port RAM between the fetch and data ports, splitting
// each big-endian byte/half/word access into one RAM byte access per cycle.
module mem_port_sequencer #(
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_req,
  input  logic [31:0]          i_addr,
  output logic                 i_done,
  output logic [31:0]          i_rdata,
  input  logic                 d_req,
  input  logic                 d_rw,
  input  logic [1:0]           d_size,
  input  logic [31:0]          d_addr,
  input  logic [31:0]          d_wdata,
  output logic                 d_done,
  output logic [31:0]          d_rdata,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic                 ram_we,
  output logic [7:0]           ram_wdata,
  input  logic [7:0]           ram_rdata,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t               state_reg, state_next;
  logic [ADDR_BITS-1:0] base_reg;
  logic                 rw_reg;
  logic                 port_d_reg;
  logic [1:0]           last_reg;
  logic [1:0]           idx_reg;
  logic [31:0]          wdata_reg;
  logic [31:0]          acc_reg;
  logic [31:0]          i_rdata_reg;
  logic [31:0]          d_rdata_reg;
  logic [31:0]          acc_shift;
  logic [1:0]           sel;
  logic [7:0]           wbytes [4];
  logic                 unused_addr_bits;

  assign unused_addr_bits = ^{i_addr[31:ADDR_BITS], d_addr[31:ADDR_BITS]};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_wbytes
      assign wbytes[gi] = wdata_reg[gi*8 +: 8];
    end
  endgenerate

  assign acc_shift = {acc_reg[23:0], ram_rdata};
  // Big-endian: byte index k carries wdata byte (nbytes-1-k).
  assign sel       = last_reg - idx_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (d_req)      state_next = (d_size == 2'b11) ? DONE : XFER;
        else if (i_req) state_next = XFER;
      end
      XFER:    if (idx_reg == last_reg) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = 8'h00;
    if (state_reg == XFER) begin
      ram_addr = base_reg + ADDR_BITS'(idx_reg);
      // Gating with reset keeps a byte from landing on the very edge that aborts the access.
      ram_we   = rw_reg & ~reset;
      if (rw_reg) ram_wdata = wbytes[sel];
    end
  end

  assign i_done  = (state_reg == DONE) && !port_d_reg;
  assign d_done  = (state_reg == DONE) &&  port_d_reg;
  assign busy    = (state_reg != IDLE);
  assign i_rdata = i_rdata_reg;
  assign d_rdata = d_rdata_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      base_reg    <= '0;
      rw_reg      <= 1'b0;
      port_d_reg  <= 1'b0;
      last_reg    <= 2'd0;
      idx_reg     <= 2'd0;
      wdata_reg   <= 32'h0;
      acc_reg     <= 32'h0;
      i_rdata_reg <= 32'h0;
      d_rdata_reg <= 32'h0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (d_req) begin
            base_reg   <= d_addr[ADDR_BITS-1:0];
            rw_reg     <= d_rw && (d_size != 2'b11);
            port_d_reg <= 1'b1;
            idx_reg    <= 2'd0;
            acc_reg    <= 32'h0;
            wdata_reg  <= d_wdata;
            case (d_size)
              2'b01:   last_reg <= 2'd1;
              2'b10:   last_reg <= 2'd3;
              default: last_reg <= 2'd0;
            endcase
            if (d_size == 2'b11) d_rdata_reg <= 32'h0;
          end else if (i_req) begin
            base_reg   <= i_addr[ADDR_BITS-1:0];
            rw_reg     <= 1'b0;
            port_d_reg <= 1'b0;
            idx_reg    <= 2'd0;
            acc_reg    <= 32'h0;
            last_reg   <= 2'd3;
          end
        end
        XFER: begin
          idx_reg <= idx_reg + 2'd1;
          acc_reg <= acc_shift;
          if (idx_reg == last_reg) begin
            if (!port_d_reg)  i_rdata_reg <= acc_shift;
            else if (!rw_reg) d_rdata_reg <= acc_shift;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_sequencer.sv
// Directed bench for mem_port_sequencer with a behavioural 256x8 RAM attached.
module tb_mem_port_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = 32'h0;
  logic        i_done;
  logic [31:0] i_rdata;
  logic        d_req = 1'b0;
  logic        d_rw = 1'b0;
  logic [1:0]  d_size = 2'b00;
  logic [31:0] d_addr = 32'h0;
  logic [31:0] d_wdata = 32'h0;
  logic        d_done;
  logic [31:0] d_rdata;
  logic [7:0]  ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  logic        busy;

  logic [7:0] mem [256] = '{default: 8'h00};
  int we_cnt = 0;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_port_sequencer #(.ADDR_BITS(8)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
    .d_req(d_req), .d_rw(d_rw), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .busy(busy)
  );

  assign ram_rdata = mem[ram_addr];

  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
      we_cnt <= we_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  // Starts #1 after a posedge with the DUT idle; returns idle the same way.
  task automatic data_xfer(input string tag, input logic rw, input logic [1:0] size,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input int exp_lat, input logic [31:0] exp_rd, input int exp_we);
    int lat;
    int w0;
    logic other;
    w0 = we_cnt; lat = -1; other = 1'b0;
    d_rw = rw; d_size = size; d_addr = addr; d_wdata = wd; d_req = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (i_done) other = 1'b1;
      if (d_done) begin lat = n; break; end
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_rdata"}, d_rdata, exp_rd);
    d_req = 1'b0;
    @(posedge clk); #1;
    check({tag, "_pulse"}, {30'h0, d_done, other | i_done}, 32'h0);
    check({tag, "_we"}, 32'(we_cnt - w0), 32'(exp_we));
  endtask

  task automatic fetch(input string tag, input logic [31:0] addr, input logic [31:0] exp_rd);
    int lat;
    int w0;
    w0 = we_cnt; lat = -1;
    i_addr = addr; i_req = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (i_done) begin lat = n; break; end
    end
    check({tag, "_lat"}, 32'(lat), 32'd5);
    check({tag, "_rdata"}, i_rdata, exp_rd);
    i_req = 1'b0;
    @(posedge clk); #1;
    check({tag, "_pulse"}, {31'h0, i_done}, 32'h0);
    check({tag, "_we"}, 32'(we_cnt - w0), 32'h0);
  endtask

  initial begin
    int td, ti, w0, cnt, prev_t;
    logic both, prev_done, wide;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_busy",  {31'h0, busy}, 32'h0);
    check("rst_done",  {30'h0, i_done, d_done}, 32'h0);
    check("rst_ram",   {15'h0, ram_we, ram_addr, ram_wdata}, 32'h0);
    check("rst_irdata", i_rdata, 32'h0);
    check("rst_drdata", d_rdata, 32'h0);

    data_xfer("wr_word", 1'b1, 2'b10, 32'h10, 32'hDEADBEEF, 5, 32'h0, 4);
    check("mem_10_13", {mem[8'h10], mem[8'h11], mem[8'h12], mem[8'h13]}, 32'hDEADBEEF);
    data_xfer("rd_word", 1'b0, 2'b10, 32'h10, 32'h0, 5, 32'hDEADBEEF, 0);
    data_xfer("rd_half", 1'b0, 2'b01, 32'h12, 32'h0, 3, 32'h0000BEEF, 0);
    data_xfer("rd_byte", 1'b0, 2'b00, 32'h11, 32'h0, 2, 32'h000000AD, 0);
    data_xfer("wr_byte", 1'b1, 2'b00, 32'h40, 32'h12345677, 2, 32'h000000AD, 1);
    check("mem_40", {24'h0, mem[8'h40]}, 32'h77);
    data_xfer("wr_half", 1'b1, 2'b01, 32'h30, 32'h9999CAFE, 3, 32'h000000AD, 2);
    check("mem_30_31", {16'h0, mem[8'h30], mem[8'h31]}, 32'hCAFE);
    data_xfer("invalid", 1'b1, 2'b11, 32'h50, 32'hFFFFFFFF, 1, 32'h0, 0);
    check("mem_50", {24'h0, mem[8'h50]}, 32'h0);

    data_xfer("wr_wrap", 1'b1, 2'b10, 32'hFE, 32'h11223344, 5, 32'h0, 4);
    check("mem_wrap", {mem[8'hFE], mem[8'hFF], mem[8'h00], mem[8'h01]}, 32'h11223344);
    fetch("fe_wrap", 32'hFE, 32'h11223344);

    // Simultaneous requests: data wins, fetch follows six cycles after d_done.
    w0 = we_cnt; td = -1; ti = -1; both = 1'b0;
    d_rw = 1'b0; d_size = 2'b10; d_addr = 32'h10; d_req = 1'b1;
    i_addr = 32'h30; i_req = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk); #1;
      if (d_done && i_done) both = 1'b1;
      if (ti < 0 && td < 0 && i_done) both = 1'b1;
      if (d_done) begin td = n; d_req = 1'b0; end
      if (i_done) begin ti = n; i_req = 1'b0; break; end
    end
    check("arb_d_lat", 32'(td), 32'd5);
    check("arb_i_gap", 32'(ti - td), 32'd6);
    check("arb_order", {31'h0, both}, 32'h0);
    check("arb_drdata", d_rdata, 32'hDEADBEEF);
    check("arb_irdata", i_rdata, 32'hCAFE0000);
    check("arb_we", 32'(we_cnt - w0), 32'h0);
    @(posedge clk); #1;

    // Reset during the second byte of a word write.
    d_rw = 1'b1; d_size = 2'b10; d_addr = 32'h20; d_wdata = 32'h55667788; d_req = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1; d_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rstw_mem", {mem[8'h20], mem[8'h21], mem[8'h22], mem[8'h23]}, 32'h55000000);
    check("rstw_state", {15'h0, busy, i_done, d_done, ram_we, ram_addr, ram_wdata[4:0]}, 32'h0);
    check("rstw_wdata", {24'h0, ram_wdata}, 32'h0);
    check("rstw_rdata", d_rdata | i_rdata, 32'h0);
    cnt = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (d_done || i_done || busy) cnt++;
    end
    check("rstw_quiet", 32'(cnt), 32'h0);

    // Back-to-back fetches with i_req held through each done.
    i_addr = 32'h10; i_req = 1'b1;
    cnt = 0; prev_t = 0; prev_done = 1'b0; wide = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (i_done && prev_done) wide = 1'b1;
      prev_done = i_done;
      if (i_done) begin
        cnt++;
        check($sformatf("b2b_gap%0d", cnt), 32'(n - prev_t), (cnt == 1) ? 32'd5 : 32'd6);
        check($sformatf("b2b_rdata%0d", cnt), i_rdata, 32'hDEADBEEF);
        prev_t = n;
        if (cnt == 3) begin i_req = 1'b0; break; end
      end
    end
    check("b2b_count", 32'(cnt), 32'd3);
    @(posedge clk); #1;
    check("b2b_width", {30'h0, wide, i_done}, 32'h0);
    check("b2b_idle", {31'h0, busy}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_sequencer.md
Name: mem_port_sequencer

Overview:
Shares one byte-wide, single-port 256x8 RAM between the instruction-fetch port and the data-memory port of the pipeline. It arbitrates between the two requesters and breaks each byte, half-word or word access into one RAM byte access per cycle. Data is big-endian: the MSB sits at the lowest address. Each requester uses a req/done handshake, and read data is returned right-justified.

Parameters:
ADDR_BITS, 8, RAM byte-address width; RAM depth is 2**ADDR_BITS.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
i_req  input  1  fetch request; held high until i_done is seen.
i_addr  input  32  fetch byte address; only [ADDR_BITS-1:0] is used.
i_done  output  1  one-cycle pulse; fetch word is valid on i_rdata.
i_rdata  output  32  fetched word.
d_req  input  1  data request; held high until d_done is seen.
d_rw  input  1  1 = write, 0 = read.
d_size  input  2  00 byte, 01 half-word, 10 word, 11 invalid.
d_addr  input  32  data byte address; only [ADDR_BITS-1:0] is used.
d_wdata  input  32  write data, right-justified.
d_done  output  1  one-cycle completion pulse.
d_rdata  output  32  read data, zero-extended and right-justified.
ram_addr  output  ADDR_BITS  RAM byte address.
ram_we  output  1  RAM write strobe, one byte per cycle.
ram_wdata  output  8  RAM write byte.
ram_rdata  input  8  RAM read byte; combinational, same cycle as ram_addr.
busy  output  1  high in XFER and DONE.

Behaviour:
- Reset values: state = IDLE; i_done = d_done = 0; i_rdata = d_rdata = 0; ram_we = 0; ram_addr = 0; ram_wdata = 0; busy = 0.
- FSM states are IDLE, XFER and DONE.
- IDLE:
  - If d_req is high, grant the data port. Latch the address, d_rw and d_size, set nbytes to 1, 2 or 4, clear the byte index and the read accumulator, then go to XFER.
  - Otherwise, if i_req is high, grant the fetch port as a word read (nbytes = 4), then go to XFER.
  - Data has fixed priority over fetch, so the older pipeline stage always progresses.
- d_size = 11: grant is taken, but no RAM access and no ram_we. The block goes IDLE -> DONE directly and returns d_rdata = 0.
- XFER, one byte per cycle, index k = 0..nbytes-1:
  - ram_addr = (base + k) mod 2**ADDR_BITS. Addresses wrap at 255 -> 0, and unaligned accesses are legal.
  - Write: ram_we = 1 and ram_wdata = d_wdata byte (nbytes-1-k).
    - Word sends [31:24], [23:16], [15:8], [7:0] in that order.
    - Half sends [15:8], then [7:0].
    - Byte sends [7:0].
  - Read: ram_we = 0 and acc <= {acc[23:0], ram_rdata}.
  - On the edge that completes k = nbytes-1, go to DONE and load acc into the granted port's rdata register.
- DONE, one cycle: assert the granted port's done (i_done or d_done), ram_we = 0, then return to IDLE.
  - Requests are not sampled in DONE; the requester drops req in this cycle.
  - A new grant can occur on the following IDLE edge.
- rdata registers hold their value until the next completion on the same port. A data write leaves d_rdata unchanged.
- Latency, from req first high in IDLE to the done pulse: word 5 cycles, half 3 cycles, byte 2 cycles, invalid size 1 cycle.
- Request inputs are latched at grant; changes during XFER are ignored.
- ram_we is never high outside XFER. No cycle has ram_we high with a fetch grant.
- Reset in any state takes effect at that edge: return to IDLE, the remaining bytes are not written, and no done pulse follows.
- Only the granted port's done may pulse, and at most one done per cycle.

Test Plan:
- Word write then read: d_rw=1, d_size=10, d_addr=0x10, d_wdata=0xDEADBEEF -> ram_we high for 4 cycles, writing 0xDE, 0xAD, 0xBE, 0xEF to 0x10..0x13. Word read of 0x10 -> d_done in cycle 5, d_rdata = 0xDEADBEEF.
- Sizes: half read at 0x12 -> d_rdata = 0x0000BEEF after 3 cycles; byte read at 0x11 -> d_rdata = 0x000000AD after 2 cycles; d_size=11 -> d_done after 1 cycle, no ram_we, d_rdata = 0.
- Wrap: word write of 0x11223344 at 0xFE -> bytes go to 0xFE, 0xFF, 0x00, 0x01. Word fetch at 0xFE -> i_rdata = 0x11223344.
- Arbitration: i_req and d_req rise in the same cycle -> data is served first, i_done follows 6 cycles after d_done, and no ram_we occurs during the fetch.
- Reset mid-write: reset asserted during the 2nd byte of a word write -> only byte 0 is written, no d_done, and all outputs return to their reset values.
- Back-to-back fetches: i_req held high through i_done and still high in the next cycle -> i_done pulses every 6 cycles and never lasts longer than 1 cycle.
